ifetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the bare PC register and direct instruction-bus hookup of the single-cycle core. It owns the fetch PC, drives the instruction bus with a valid/addr_ok/data_ok handshake (at most one request outstanding), and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready port. A redirect from execute flushes the FIFO and restarts fetch.

---
 rtl/ifetch_queue.sv | 138 +++++++++++++
 tb/tb_ifetch_queue.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one bus request at a time,
// and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO drained by decode.
module ifetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_addr_ok,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    input  logic            out_ready
);

    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_IDLE = 2'd2} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic            drop_q, drop_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic completing, inflight, enq, deq, has_space;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign inflight   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign completing = ((state_q == S_REQ) && iresp_addr_ok && iresp_data_ok) ||
                        ((state_q == S_WAIT) && iresp_data_ok);
    assign deq        = out_valid && out_ready;
    // Data returning under a redirect or a pending drop belongs to the abandoned path.
    assign enq        = completing && !drop_q && !redirect_valid;
    // Space is judged on the post-update occupancy so the next request always has a slot.
    assign has_space  = count_d < DEPTH_C;

    // FIFO pointers, occupancy and the next sequential fetch PC.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        next_pc_d = next_pc_q;
        if (redirect_valid) begin
            head_d    = tail_q;
            count_d   = '0;
            next_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (deq) head_d = head_q + PW'(1);
            if (enq) begin
                tail_d    = tail_q + PW'(1);
                next_pc_d = req_addr_q + XLEN'(4);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        case (state_q)
            S_REQ: begin
                if (completing)         state_d = has_space ? S_REQ : S_IDLE;
                else if (iresp_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (completing) state_d = has_space ? S_REQ : S_IDLE;
            end
            S_IDLE: begin
                if (has_space) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        // A fresh request loads its address; a REQ still waiting for addr_ok keeps the old one.
        if ((state_d == S_REQ) && (completing || (state_q == S_IDLE))) req_addr_d = next_pc_d;
        if (completing)                       drop_d = 1'b0;
        else if (redirect_valid && inflight)  drop_d = 1'b1;
    end

    // Output logic.
    always_comb begin
        ireq_valid = (state_q == S_REQ);
        ireq_addr  = req_addr_q;
        out_valid  = (count_q != '0);
        out_pc     = pc_mem[head_q];
        out_instr  = instr_mem[head_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_REQ;
        else       state_q <= state_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_q <= RESET_PC;
            next_pc_q  <= RESET_PC + XLEN'(4);
            drop_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            req_addr_q <= req_addr_d;
            next_pc_q  <= next_pc_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only read while count marks them valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q]    <= req_addr_q;
            instr_mem[tail_q] <= iresp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a randomized bus,
// redirect and decode-stall mix checked against a queue-based reference model.
module tb_ifetch_queue;

    localparam int          XLEN     = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic            clk;
    logic            reset;
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_addr_ok;
    logic            iresp_data_ok;
    logic [31:0]     iresp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_ready;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    // Reference model: program-order queue of fetched instructions plus the single
    // outstanding bus transaction (presented or accepted) and a drop marker.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_q[$];
    bit          m_presenting, m_waiting, m_drop;
    logic [63:0] m_addr, m_fetch_pc;

    task automatic model_reset();
        m_q.delete();
        m_presenting = 1'b1;
        m_waiting    = 1'b0;
        m_drop       = 1'b0;
        m_addr       = RESET_PC;
        m_fetch_pc   = RESET_PC + 64'd4;
    endtask

    task automatic model_update();
        bit done, busy;
        busy = m_presenting || m_waiting;
        done = (m_presenting && iresp_addr_ok && iresp_data_ok) || (m_waiting && iresp_data_ok);
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (redirect_valid) begin
            m_q.delete();
            m_fetch_pc = {redirect_pc[63:2], 2'b00};
        end else if (done && !m_drop) begin
            m_q.push_back('{pc: m_addr, instr: iresp_data});
            m_fetch_pc = m_addr + 64'd4;
        end
        if (done)                        m_drop = 1'b0;
        else if (redirect_valid && busy) m_drop = 1'b1;
        if (done) begin
            m_presenting = 1'b0;
            m_waiting    = 1'b0;
        end else if (m_presenting && iresp_addr_ok) begin
            m_presenting = 1'b0;
            m_waiting    = 1'b1;
        end
        if (!m_presenting && !m_waiting && m_q.size() < DEPTH) begin
            m_presenting = 1'b1;
            m_addr       = m_fetch_pc;
        end
    endtask

    task automatic check_outputs();
        check("ireq_valid", ireq_valid, m_presenting);
        if (m_presenting) check("ireq_addr", ireq_addr, m_addr);
        check("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_instr", out_instr, m_q[0].instr);
        end
    endtask

    // Inputs for the current cycle are already applied; advance one edge and compare.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
    endtask

    // Bench-side bus: accepts a presented request with some probability and
    // returns its data after 0..lat_max cycles.
    bit          bus_busy;
    int          bus_cnt;
    logic [63:0] bus_addr;

    task automatic bus_drive(input int lat_max, input int accept_pct);
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = $urandom;
        if (bus_busy) begin
            bus_cnt--;
            if (bus_cnt == 0) begin
                iresp_data_ok = 1'b1;
                iresp_data    = instr_of(bus_addr);
                bus_busy      = 1'b0;
            end
        end else if (m_presenting && ($urandom_range(99) < accept_pct)) begin
            iresp_addr_ok = 1'b1;
            bus_addr      = m_addr;
            bus_cnt       = $urandom_range(lat_max, 0);
            if (bus_cnt == 0) begin
                iresp_data_ok = 1'b1;
                iresp_data    = instr_of(bus_addr);
            end else begin
                bus_busy = 1'b1;
            end
        end
    endtask

    task automatic zero_lat_fetch();
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = instr_of(m_addr);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        bus_busy = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_req;
        reset = 1'b1;
        idle_inputs();

        // Reset state and one instruction per cycle on a zero-latency bus.
        apply_reset();
        check("rst_ireq_valid", ireq_valid, 1'b1);
        check("rst_ireq_addr", ireq_addr, RESET_PC);
        check("rst_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            zero_lat_fetch();
            out_ready = 1'b1;
            step();
            check("stream_out_pc", out_pc, RESET_PC + 64'(4 * i));
            check("stream_out_instr", out_instr, instr_of(RESET_PC + 64'(4 * i)));
            check("stream_ireq_addr", ireq_addr, RESET_PC + 64'(4 * (i + 1)));
        end

        // Full FIFO stops fetch; one dequeue re-opens exactly one request.
        apply_reset();
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (ireq_valid) begin
                check("full_req_addr", ireq_addr, RESET_PC + 64'(4 * n_req));
                n_req++;
                iresp_addr_ok = 1'b1;
                iresp_data_ok = 1'b1;
                iresp_data    = instr_of(ireq_addr);
            end
            step();
        end
        check("full_req_count", 64'(n_req), 64'd4);
        check("full_ireq_valid", ireq_valid, 1'b0);
        idle_inputs();
        out_ready = 1'b1;
        step();
        check("reopen_ireq_valid", ireq_valid, 1'b1);
        check("reopen_ireq_addr", ireq_addr, RESET_PC + 64'h10);

        // Redirect while waiting on a slow response.
        apply_reset();
        zero_lat_fetch();
        step();
        idle_inputs();
        iresp_addr_ok = 1'b1;
        step();
        idle_inputs();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        step();
        check("wait_redir_empty", out_valid, 1'b0);
        idle_inputs();
        step();
        iresp_data_ok = 1'b1;
        iresp_data    = instr_of(64'h8000_0004);
        step();
        check("wait_redir_dropped", out_valid, 1'b0);
        check("wait_redir_ireq_valid", ireq_valid, 1'b1);
        check("wait_redir_ireq_addr", ireq_addr, 64'h8000_0100);

        // Redirect while the request is still waiting for addr_ok.
        apply_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        step();
        check("req_redir_hold_addr", ireq_addr, RESET_PC);
        idle_inputs();
        step();
        check("req_redir_hold_addr2", ireq_addr, RESET_PC);
        zero_lat_fetch();
        step();
        check("req_redir_dropped", out_valid, 1'b0);
        check("req_redir_new_addr", ireq_addr, 64'h8000_0200);
        zero_lat_fetch();
        step();
        check("req_redir_first_pc", out_pc, 64'h8000_0200);

        // Redirect coincident with data_ok and a dequeue.
        apply_reset();
        zero_lat_fetch();
        step();
        idle_inputs();
        iresp_addr_ok = 1'b1;
        step();
        idle_inputs();
        iresp_data_ok  = 1'b1;
        iresp_data     = instr_of(64'h8000_0004);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        step();
        check("coinc_empty", out_valid, 1'b0);
        check("coinc_ireq_addr", ireq_addr, 64'h8000_0300);
        idle_inputs();
        zero_lat_fetch();
        step();
        check("coinc_no_drop", out_valid, 1'b1);
        check("coinc_no_drop_pc", out_pc, 64'h8000_0300);

        // Asynchronous reset mid-WAIT, then a stray data_ok after release.
        apply_reset();
        zero_lat_fetch();
        step();
        idle_inputs();
        iresp_addr_ok = 1'b1;
        step();
        idle_inputs();
        #3;
        reset = 1'b1;
        model_reset();
        bus_busy = 1'b0;
        #1;
        check("async_rst_ireq_valid", ireq_valid, 1'b1);
        check("async_rst_ireq_addr", ireq_addr, RESET_PC);
        check("async_rst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        step();
        check("stray_out_valid", out_valid, 1'b0);
        check("stray_ireq_addr", ireq_addr, RESET_PC);

        // Randomized traffic against the reference model.
        apply_reset();
        for (int phase = 0; phase < 6; phase++) begin
            int lat_max, accept_pct, ready_pct, redir_pct;
            lat_max    = $urandom_range(3);
            accept_pct = $urandom_range(100, 30);
            ready_pct  = $urandom_range(100, 0);
            redir_pct  = $urandom_range(15, 2);
            for (int c = 0; c < 500; c++) begin
                bus_drive(lat_max, accept_pct);
                out_ready      = ($urandom_range(99) < ready_pct);
                redirect_valid = ($urandom_range(99) < redir_pct);
                redirect_pc    = {$urandom, $urandom};
                if ($urandom_range(3) == 0)
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF4 ^ 64'($urandom_range(3));
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
